// File: rtl/counter_pkg.sv
// Shared mode encodings, slice width and operand helper for counter_n.
package counter_pkg;

    localparam int unsigned SLICE_W  = 4;
    localparam int unsigned OP_MAX_W = 256;

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,
        MODE_DN  = 2'b01,
        MODE_DN3 = 2'b10,
        MODE_LD  = 2'b11
    } mode_e;

    // Sign-extended operand for the selected mode; bits at and above width are cleared.
    function automatic logic [OP_MAX_W-1:0] op_vec(input mode_e mode, input int unsigned width);
        logic [OP_MAX_W-1:0] v;
        v = '0;
        case (mode)
            MODE_UP:  v = OP_MAX_W'(1);
            MODE_DN:  v = '1;
            MODE_DN3: v = ~OP_MAX_W'(2);
            MODE_LD:  v = '0;
            default:  v = '0;
        endcase
        for (int unsigned i = 0; i < OP_MAX_W; i++) begin
            if (i >= width) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/count_slice.sv
// One SLICE_W-bit ripple segment of the counter adder; purely combinational.
module count_slice
    import counter_pkg::*;
#(
    parameter int unsigned W = SLICE_W
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] op,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total       = {1'b0, q} + {1'b0, op} + {{W{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/counter_n.sv
// Parametrised up/down/down-by-3/load counter with a registered wrap/clamp pulse.
// Define COUNTER_SAT_EN for saturating behaviour instead of modular wrap.
module counter_n
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco
);

    localparam int unsigned N_SLICES = WIDTH / SLICE_W;

    if (WIDTH == 0 || (WIDTH % SLICE_W) != 0 || WIDTH > OP_MAX_W) begin : g_bad_width
        $error("counter_n: WIDTH must be a non-zero multiple of SLICE_W");
    end

    mode_e              mode_c;
    logic [WIDTH-1:0]   op_c;
    logic [WIDTH-1:0]   sum_c;
    logic [N_SLICES:0]  carry_c;
    logic               cout_c;
    logic               wrap_c;
    logic [WIDTH-1:0]   q_next_c;
    logic               rco_next_c;

    assign mode_c     = mode_e'(modo);
    assign op_c       = WIDTH'(op_vec(mode_c, WIDTH));
    assign carry_c[0] = 1'b0;
    assign cout_c     = carry_c[N_SLICES];

    // Single WIDTH-bit add built from chained slices; carries ripple within the cycle.
    for (genvar s = 0; s < int'(N_SLICES); s++) begin : g_slice
        count_slice #(.W(SLICE_W)) u_slice (
            .q    (Q[s*SLICE_W +: SLICE_W]),
            .op   (op_c[s*SLICE_W +: SLICE_W]),
            .cin  (carry_c[s]),
            .sum  (sum_c[s*SLICE_W +: SLICE_W]),
            .cout (carry_c[s+1])
        );
    end

    // Up wraps on carry-out; down modes wrap when the add produces no carry (borrow).
    always_comb begin
        wrap_c = 1'b0;
        case (mode_c)
            MODE_UP:  wrap_c = cout_c;
            MODE_DN:  wrap_c = ~cout_c;
            MODE_DN3: wrap_c = ~cout_c;
            default:  wrap_c = 1'b0;
        endcase
    end

    always_comb begin
        q_next_c   = Q;
        rco_next_c = 1'b0;
        if (enable) begin
            if (mode_c == MODE_LD) begin
                q_next_c = D;
            end else if (wrap_c) begin
                rco_next_c = 1'b1;
`ifdef COUNTER_SAT_EN
                q_next_c   = (mode_c == MODE_UP) ? '1 : '0;
`else
                q_next_c   = sum_c;
`endif
            end else begin
                q_next_c = sum_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q   <= RST_VAL;
            rco <= 1'b0;
        end else begin
            Q   <= q_next_c;
            rco <= rco_next_c;
        end
    end

endmodule

// File: tb/tb_counter_n.sv
// Self-checking bench for counter_n: directed vector table, reset/carry corner cases,
// and randomized traffic on 8- and 32-bit instances against an arithmetic reference model.
module tb_counter_n;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en8, en32;
    logic [1:0]  m8, m32;
    logic [7:0]  d8, q8;
    logic        r8;
    logic [31:0] d32, q32;
    logic        r32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_n #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .enable (en8),
        .modo   (m8),
        .D      (d8),
        .Q      (q8),
        .rco    (r8)
    );

    counter_n #(.WIDTH(32)) dut32 (
        .clk    (clk),
        .reset  (reset),
        .enable (en32),
        .modo   (m32),
        .D      (d32),
        .Q      (q32),
        .rco    (r32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the mode rules; returns {rco, q}.
    function automatic logic [32:0] ref_next(input longint unsigned q, input logic en,
                                             input logic [1:0] m, input longint unsigned d,
                                             input int w);
        longint unsigned maxv, nq;
        logic            rc;
        maxv = (64'd1 << w) - 64'd1;
        nq   = q;
        rc   = 1'b0;
        if (en) begin
            case (m)
                2'd0: if (q == maxv) begin rc = 1'b1; nq = SAT ? maxv : 0; end
                      else nq = q + 1;
                2'd1: if (q < 1) begin rc = 1'b1; nq = SAT ? 0 : maxv; end
                      else nq = q - 1;
                2'd2: if (q < 3) begin rc = 1'b1; nq = SAT ? 0 : (q + maxv + 1 - 3); end
                      else nq = q - 3;
                default: nq = d & maxv;
            endcase
        end
        return {rc, 32'(nq)};
    endfunction

    function automatic longint unsigned pick_d(input int w);
        longint unsigned maxv;
        maxv = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 6))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return maxv;
            4: return maxv - 1;
            default: return longint'($urandom) & maxv;
        endcase
    endfunction

    typedef struct {
        logic       en;
        logic [1:0] m;
        logic [7:0] d;
        logic [7:0] q;
        logic       rco;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    longint unsigned mq8, mq32;
    logic [32:0]     e8, e32;

    initial begin
        // Sequence from reset (Q=0) on the 8-bit instance: one record per clock.
        vecs[0]  = '{1'b1, 2'd3, 8'hFE, 8'hFE, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 8'h00, 8'hFF, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 8'h00, SAT ? 8'hFF : 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 8'h00, 8'h01, 1'b0};
        vecs[5]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 8'h00, SAT ? 8'h00 : 8'hFF, 1'b1};
        vecs[7]  = '{1'b1, 2'd3, 8'h02, 8'h02, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 8'h00, SAT ? 8'h00 : 8'hFF, 1'b1};
        vecs[9]  = '{1'b1, 2'd3, 8'h06, 8'h06, 1'b0};
        vecs[10] = '{1'b1, 2'd2, 8'h00, 8'h03, 1'b0};
        vecs[11] = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 2'd3, 8'hA5, 8'hA5, 1'b0};
        vecs[14] = '{1'b0, 2'd3, 8'h5A, 8'hA5, 1'b0};
        vecs[15] = '{1'b1, 2'd3, 8'h01, 8'h01, 1'b0};
        vecs[16] = '{1'b1, 2'd2, 8'h00, SAT ? 8'h00 : 8'hFE, 1'b1};
        vecs[17] = '{1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0};
        vecs[18] = '{1'b1, 2'd0, 8'h00, SAT ? 8'hFF : 8'h00, 1'b1};
        vecs[19] = '{1'b1, 2'd0, 8'h00, SAT ? 8'hFF : 8'h01, SAT};
        vecs[20] = '{1'b0, 2'd1, 8'h00, SAT ? 8'hFF : 8'h01, 1'b0};

        reset = 1'b1;
        en8 = 1'b0; m8 = 2'd0; d8 = '0;
        en32 = 1'b0; m32 = 2'd0; d32 = '0;
        #2;
        chk("reset_q8", 64'(q8), 64'h0);
        chk("reset_rco8", 64'(r8), 64'h0);
        chk("reset_q32", 64'(q32), 64'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            en8 = vecs[i].en; m8 = vecs[i].m; d8 = vecs[i].d;
            tick();
            chk($sformatf("vec%0d_q", i), 64'(q8), 64'(vecs[i].q));
            chk($sformatf("vec%0d_rco", i), 64'(r8), 64'(vecs[i].rco));
        end

        // Asynchronous reset in the middle of a count, checked before the next edge.
        en8 = 1'b1; m8 = 2'd3; d8 = 8'h37;
        tick();
        chk("pre_rst_q", 64'(q8), 64'h37);
        m8 = 2'd0;
        #3 reset = 1'b1;
        #1;
        chk("async_rst_q", 64'(q8), 64'h0);
        chk("async_rst_rco", 64'(r8), 64'h0);
        tick();
        chk("held_rst_q", 64'(q8), 64'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_q", 64'(q8), 64'h1);

        // Reset clears a pending rco pulse immediately.
        m8 = 2'd3; d8 = 8'hFF;
        tick();
        m8 = 2'd0;
        tick();
        chk("wrap_rco_set", 64'(r8), 64'h1);
        #3 reset = 1'b1;
        #1;
        chk("rst_clr_rco", 64'(r8), 64'h0);
        chk("rst_clr_q", 64'(q8), 64'h0);
        tick();
        reset = 1'b0;
        en8 = 1'b0;

        // Full carry/borrow propagation across every slice of the 32-bit instance.
        en32 = 1'b1; m32 = 2'd3; d32 = 32'h0000FFFF;
        tick();
        chk("ld32", 64'(q32), 64'h0000FFFF);
        m32 = 2'd0;
        tick();
        chk("up32_carry_q", 64'(q32), 64'h00010000);
        chk("up32_carry_rco", 64'(r32), 64'h0);
        m32 = 2'd1;
        tick();
        chk("dn32_borrow_q", 64'(q32), 64'h0000FFFF);
        m32 = 2'd3; d32 = 32'hFFFFFFFF;
        tick();
        m32 = 2'd0;
        tick();
        chk("up32_wrap_q", 64'(q32), SAT ? 64'hFFFFFFFF : 64'h0);
        chk("up32_wrap_rco", 64'(r32), 64'h1);
        m32 = 2'd3; d32 = 32'h00000000;
        tick();
        mq8  = 0;
        mq32 = 0;
        chk("sync_q8", 64'(q8), 64'h0);
        chk("sync_q32", 64'(q32), 64'h0);

        // Randomized traffic on both instances against the reference model.
        for (int c = 0; c < 600; c++) begin
            en8  = ($urandom_range(0, 9) != 0);
            m8   = 2'($urandom_range(0, 3));
            d8   = 8'(pick_d(8));
            en32 = ($urandom_range(0, 9) != 0);
            m32  = 2'($urandom_range(0, 3));
            d32  = 32'(pick_d(32));
            e8   = ref_next(mq8, en8, m8, 64'(d8), 8);
            e32  = ref_next(mq32, en32, m32, 64'(d32), 32);
            tick();
            chk($sformatf("rnd%0d_q8", c), 64'(q8), 64'(e8[7:0]));
            chk($sformatf("rnd%0d_rco8", c), 64'(r8), 64'(e8[32]));
            chk($sformatf("rnd%0d_q32", c), 64'(q32), 64'(e32[31:0]));
            chk($sformatf("rnd%0d_rco32", c), 64'(r32), 64'(e32[32]));
            mq8  = 64'(e8[7:0]);
            mq32 = 64'(e32[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
